// File: rtl/dly_pkg.sv
// Shared constants and helpers for the signal delay line.
// Depth limits and a constant-foldable ceiling log2.
package dly_pkg;

    localparam int MAX_DEPTH   = 1024;
    localparam int SHIFT_LIMIT = 16;

    // Ceiling log2, never less than 1 so it can size a vector
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dly_stage.sv
// One WIDTH-bit pipeline register of the delay line.
// Synchronous active-high reset loads RESET_VAL.
module dly_stage
    import dly_pkg::*;
#(
    parameter int              WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Single register stage; every edge captures d
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VAL;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/signal_delay_line.sv
// Fixed-latency delay line: dout is din delayed by DEPTH edges.
// Shift register for short depths, ring buffer for long ones.
module signal_delay_line
    import dly_pkg::*;
#(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             primed
);

    if (DEPTH < 0 || DEPTH > MAX_DEPTH || WIDTH < 1) begin : g_bad_cfg
        $error("signal_delay_line: illegal WIDTH/DEPTH");
    end

    if (DEPTH == 0) begin : g_wire
        logic unused_clk;
        assign unused_clk = clk;
        assign dout       = din;
        assign primed     = ~rst;
    end else begin : g_delay
        localparam int CW = clog2(DEPTH + 1);

        logic [CW-1:0] fill_cnt;

        // Count post-reset edges up to DEPTH, then hold
        always_ff @(posedge clk) begin
            if (rst) begin
                fill_cnt <= '0;
            end else if (fill_cnt != CW'(DEPTH)) begin
                fill_cnt <= fill_cnt + 1'b1;
            end
        end

        assign primed = (fill_cnt == CW'(DEPTH));

        if (DEPTH <= SHIFT_LIMIT) begin : g_shift
            logic [WIDTH-1:0] tap [DEPTH+1];

            assign tap[0] = din;

            for (genvar i = 0; i < DEPTH; i++) begin : g_stage
                dly_stage #(
                    .WIDTH    (WIDTH),
                    .RESET_VAL(RESET_VAL)
                ) u_stage (
                    .clk(clk),
                    .rst(rst),
                    .d  (tap[i]),
                    .q  (tap[i+1])
                );
            end

            assign dout = tap[DEPTH];
        end else begin : g_ring
            localparam int PW = clog2(DEPTH);

            logic [WIDTH-1:0] mem [DEPTH];
            logic [PW-1:0]    ptr;

            // Slot at ptr holds the sample taken DEPTH edges ago;
            // read it out, then overwrite it with the new sample
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        mem[i] <= RESET_VAL;
                    end
                    ptr <= '0;
                end else begin
                    mem[ptr] <= din;
                    if (ptr == PW'(DEPTH - 1)) begin
                        ptr <= '0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
            end

            assign dout = mem[ptr];
        end
    end

endmodule

// File: tb/tb_signal_delay_line.sv
// Randomized bench for signal_delay_line across several configurations.
// A queue-based model of post-reset samples predicts every output.
module tb_signal_delay_line;

    localparam int NI = 7;
    localparam int NCYC = 130;

    // 0:A W1 D1, 1:B W8 D5, 2:LEDR d, 3:LEDR r, 4:ring D20, 5:D4 mid rst, 6:D0
    localparam int DEP [NI] = '{1, 5, 1, 1, 20, 4, 0};
    localparam logic [7:0] RV [NI] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h3C, 8'hA5, 8'h00};
    localparam logic [7:0] MSK [NI] = '{8'h01, 8'hFF, 8'h01, 8'h01, 8'hFF, 8'hFF, 8'h01};

    logic       clk = 1'b0;
    logic       rst_v  [NI];
    logic [7:0] din_v  [NI];
    logic [7:0] dout_a [NI];
    logic       prim_a [NI];

    logic       a_dout, ld_dout, lr_dout, e_dout;
    logic [7:0] b_dout, c_dout, d_dout;
    logic       a_prim, b_prim, ld_prim, lr_prim, c_prim, d_prim, e_prim;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] hist [NI][$];

    always #5 clk = ~clk;

    signal_delay_line #(.WIDTH(1), .DEPTH(1), .RESET_VAL(1'b0)) u_a (
        .clk(clk), .rst(rst_v[0]), .din(din_v[0][0:0]),
        .dout(a_dout), .primed(a_prim));

    signal_delay_line #(.WIDTH(8), .DEPTH(5), .RESET_VAL(8'h00)) u_b (
        .clk(clk), .rst(rst_v[1]), .din(din_v[1]),
        .dout(b_dout), .primed(b_prim));

    signal_delay_line #(.WIDTH(1), .DEPTH(1), .RESET_VAL(1'b0)) u_ld (
        .clk(clk), .rst(rst_v[2]), .din(din_v[2][0:0]),
        .dout(ld_dout), .primed(ld_prim));

    signal_delay_line #(.WIDTH(1), .DEPTH(1), .RESET_VAL(1'b0)) u_lr (
        .clk(clk), .rst(rst_v[3]), .din(din_v[3][0:0]),
        .dout(lr_dout), .primed(lr_prim));

    signal_delay_line #(.WIDTH(8), .DEPTH(20), .RESET_VAL(8'h3C)) u_c (
        .clk(clk), .rst(rst_v[4]), .din(din_v[4]),
        .dout(c_dout), .primed(c_prim));

    signal_delay_line #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'hA5)) u_d (
        .clk(clk), .rst(rst_v[5]), .din(din_v[5]),
        .dout(d_dout), .primed(d_prim));

    signal_delay_line #(.WIDTH(1), .DEPTH(0), .RESET_VAL(1'b0)) u_e (
        .clk(clk), .rst(rst_v[6]), .din(din_v[6][0:0]),
        .dout(e_dout), .primed(e_prim));

    always_comb begin
        dout_a[0] = {7'd0, a_dout};
        dout_a[1] = b_dout;
        dout_a[2] = {7'd0, ld_dout};
        dout_a[3] = {7'd0, lr_dout};
        dout_a[4] = c_dout;
        dout_a[5] = d_dout;
        dout_a[6] = {7'd0, e_dout};
        prim_a[0] = a_prim;
        prim_a[1] = b_prim;
        prim_a[2] = ld_prim;
        prim_a[3] = lr_prim;
        prim_a[4] = c_prim;
        prim_a[5] = d_prim;
        prim_a[6] = e_prim;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        logic [5:0] tok_seq;
        logic       src_d, src_r, tok, par;
        logic       prev_d, prev_r;
        int         n;
        logic [7:0] exp_v;
        logic       exp_p;

        tok_seq = 6'b100110;
        src_d   = 1'b0;
        src_r   = 1'b0;
        prev_d  = 1'b0;
        prev_r  = 1'b0;
        for (int i = 0; i < NI; i++) begin
            rst_v[i] = 1'b1;
            din_v[i] = '0;
        end

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            // Drive inputs for this edge
            for (int i = 0; i < NI; i++) begin
                rst_v[i] = (cyc < 3) || (cyc == 60) || (cyc == 110);
            end
            rst_v[4] = (cyc < 3);

            din_v[0] = (cyc < 4) ? 8'd1 : 8'($urandom_range(0, 1));
            din_v[1] = 8'(cyc + 1);
            din_v[4] = 8'($urandom);
            din_v[5] = 8'($urandom);
            din_v[6] = {7'd0, cyc[0]};

            if (cyc >= 3) begin
                tok = (cyc <= 8) ? tok_seq[cyc-3] : 1'($urandom_range(0, 1));
                par   = ~(src_d ^ src_r);
                src_d = tok;
                src_r = tok ^ par;
            end
            din_v[2] = {7'd0, src_d};
            din_v[3] = {7'd0, src_r};

            @(posedge clk);
            for (int i = 0; i < NI; i++) begin
                if (rst_v[i]) begin
                    hist[i].delete();
                end else begin
                    hist[i].push_back(din_v[i] & MSK[i]);
                end
            end

            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if (DEP[i] == 0) begin
                    exp_v = din_v[i] & MSK[i];
                    exp_p = ~rst_v[i];
                end else begin
                    n = hist[i].size();
                    exp_p = (n >= DEP[i]);
                    exp_v = exp_p ? hist[i][n-DEP[i]] : RV[i];
                end
                check($sformatf("dout%0d@%0d", i, cyc), 32'(dout_a[i]), 32'(exp_v));
                check($sformatf("primed%0d@%0d", i, cyc), 32'(prim_a[i]), 32'(exp_p));
            end

            if (cyc >= 3 && cyc <= 8) begin
                check($sformatf("ledr_tok@%0d", cyc), 32'(ld_dout), 32'(tok_seq[cyc-3]));
                check($sformatf("ledr_tgl@%0d", cyc),
                      32'(int'(ld_dout ^ prev_d) + int'(lr_dout ^ prev_r)), 32'd1);
            end
            prev_d = ld_dout;
            prev_r = lr_dout;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
